// File: rtl/shift_load_controller.sv
// Serial shift-register load controller.
// Accepts a WIDTH-bit word, clears an external shift register, shifts the
// word in MSB first, reads the register back and reports match / mismatch.
module shift_load_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  input  logic             abort,
  output logic             sr_reset,
  output logic             sr_data,
  output logic             sr_shift_enable,
  input  logic [WIDTH-1:0] sr_stored_data,
  output logic             done,
  output logic             match,
  output logic [7:0]       fail_count
);

  // Bit counter only needs to reach WIDTH-1; the transition to CHECK happens
  // on the edge of the last enabled shift.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] latched_q;
  logic             done_q;
  logic             match_q;
  logic [7:0]       fail_q;

  logic [CW-1:0]    bit_idx;
  logic             readback_ok;

  // Index of the bit currently presented: MSB first, so it walks down from
  // WIDTH-1 as the counter walks up. Held constant while stalled.
  assign bit_idx     = LAST_BIT - count_q;
  assign readback_ok = (sr_stored_data == latched_q);

  // Main controller FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      latched_q <= '0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
      fail_q    <= 8'd0;
    end else begin
      // done is a single-cycle pulse; only CHECK re-arms it.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Abort is meaningless here and is ignored.
          if (in_valid) begin
            latched_q <= in_data;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          count_q <= '0;
          if (abort) begin
            state_q <= IDLE;
          end else begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // Abort wins over stall; stall freezes progress indefinitely.
          if (abort) begin
            state_q <= IDLE;
            count_q <= '0;
          end else if (!stall) begin
            if (count_q == LAST_BIT) begin
              state_q <= CHECK;
              count_q <= '0;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        CHECK: begin
          state_q <= IDLE;
          // An aborted check leaves done, match and fail_count untouched.
          if (!abort) begin
            done_q  <= 1'b1;
            match_q <= readback_ok;
            if (!readback_ok && (fail_q != 8'hFF)) begin
              fail_q <= fail_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake and shift-register drive. Reset is OR-ed into sr_reset so the
  // external register clears in the same cycle the controller does.
  always_comb begin
    in_ready        = (state_q == IDLE);
    sr_reset        = reset || (state_q == CLEAR);
    sr_shift_enable = (state_q == SHIFT) && !stall && !abort && !reset;
    sr_data         = (state_q == SHIFT) ? latched_q[bit_idx] : 1'b0;
  end

  assign done       = done_q;
  assign match      = match_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_shift_load_controller.sv
// Self-checking bench for shift_load_controller with a behavioural model of
// the driven shift register (and an option to force its readback to zero).
module tb_shift_load_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       stall;
  logic       abort;
  logic       sr_reset;
  logic       sr_data;
  logic       sr_shift_enable;
  logic [7:0] sr_stored_data;
  logic       done;
  logic       match;
  logic [7:0] fail_count;

  logic [7:0] sr_model;
  logic       force_zero = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_load_controller #(.WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .stall          (stall),
    .abort          (abort),
    .sr_reset       (sr_reset),
    .sr_data        (sr_data),
    .sr_shift_enable(sr_shift_enable),
    .sr_stored_data (sr_stored_data),
    .done           (done),
    .match          (match),
    .fail_count     (fail_count)
  );

  // External shift register being driven.
  always @(posedge clk) begin
    if (sr_reset) sr_model <= 8'h00;
    else if (sr_shift_enable) sr_model <= {sr_model[6:0], sr_data};
  end
  assign sr_stored_data = force_zero ? 8'h00 : sr_model;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       st;
    logic       ab;
    logic       e_ready;
    logic       e_srst;
    logic       e_en;
    logic       e_sdata;
    logic       e_done;
    logic       e_match;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs are sampled 1ns later.
  task automatic step(input logic v, input logic [7:0] d, input logic st,
                      input logic ab, input logic rs);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    stall    = st;
    abort    = ab;
    reset    = rs;
    #1;
  endtask

  // Accept a word and wait (bounded) for done; lat is the done cycle or -1.
  task automatic do_load(input logic [7:0] d, output int lat, output logic m);
    lat = -1;
    m   = 1'bx;
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 40; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (done) begin
        lat = i;
        m   = match;
        break;
      end
    end
  endtask

  int   lat;
  logic m;
  int   en_cnt;
  int   done_cnt;
  int   done_c1;
  int   done_c2;
  logic m1;
  logic m2;

  initial begin
    // Load 8'hA5 at cycle 0, no stall, straight after reset.
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    in_valid = 1'b0; in_data = 8'h00; stall = 1'b0; abort = 1'b0; reset = 1'b1;

    // Reset state, with in_valid and abort asserted to show reset overrides.
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
    chk("rst_sr_reset", sr_reset, 1'b1);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_match", match, 1'b0);
    chk("rst_fail_count", fail_count, 8'd0);
    chk("rst_enable", sr_shift_enable, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Table-driven A5 load.
    for (int c = 0; c < 13; c++) begin
      step(tbl[c].valid, tbl[c].data, tbl[c].st, tbl[c].ab, 1'b0);
      chk($sformatf("a5_c%0d_ready", c), in_ready, tbl[c].e_ready);
      chk($sformatf("a5_c%0d_sr_reset", c), sr_reset, tbl[c].e_srst);
      chk($sformatf("a5_c%0d_enable", c), sr_shift_enable, tbl[c].e_en);
      chk($sformatf("a5_c%0d_sr_data", c), sr_data, tbl[c].e_sdata);
      chk($sformatf("a5_c%0d_done", c), done, tbl[c].e_done);
      chk($sformatf("a5_c%0d_match", c), match, tbl[c].e_match);
    end
    chk("a5_fail_count", fail_count, 8'd0);

    // 8'h3C with stall in cycles 4-6: done at 14, eight enables, sr_data held.
    en_cnt = 0; done_c1 = -1; m1 = 1'bx;
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      step(1'b0, 8'h00, (c >= 4 && c <= 6), 1'b0, 1'b0);
      if (sr_shift_enable) en_cnt++;
      if (c >= 4 && c <= 7) chk($sformatf("stall_c%0d_sr_data", c), sr_data, 1'b1);
      if (c >= 4 && c <= 6) chk($sformatf("stall_c%0d_enable", c), sr_shift_enable, 1'b0);
      if (done && done_c1 < 0) begin done_c1 = c; m1 = match; end
    end
    chk("stall_enables", en_cnt, 8);
    chk("stall_done_cycle", done_c1, 14);
    chk("stall_match", m1, 1'b1);

    // Forced mismatch: 8'hFF read back as 8'h00.
    force_zero = 1'b1;
    do_load(8'hFF, lat, m);
    chk("mm_latency", lat, 11);
    chk("mm_match", m, 1'b0);
    chk("mm_fail_count", fail_count, 8'd1);
    for (int k = 2; k <= 256; k++) begin
      do_load(8'hFF, lat, m);
      if (lat < 0) chk("mm_loop_timeout", lat, 11);
      if (k == 255) chk("mm_fail_count_255", fail_count, 8'd255);
    end
    chk("mm_fail_count_sat", fail_count, 8'd255);
    chk("mm_match_last", match, 1'b0);
    force_zero = 1'b0;

    // Reset clears the saturated counter.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst2_fail_count", fail_count, 8'd0);

    // 8'h81 with reset in cycle 5.
    done_cnt = 0;
    step(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst81_c5_sr_reset", sr_reset, 1'b1);
    for (int c = 6; c <= 20; c++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (c == 6) chk("rst81_c6_in_ready", in_ready, 1'b1);
      if (done) done_cnt++;
    end
    chk("rst81_no_done", done_cnt, 0);
    chk("rst81_fail_count", fail_count, 8'd0);

    // 8'h55 with abort in cycle 6.
    done_cnt = 0; en_cnt = 0;
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int c = 7; c <= 20; c++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (c == 7) chk("abort_c7_in_ready", in_ready, 1'b1);
      if (sr_shift_enable) en_cnt++;
      if (done) done_cnt++;
    end
    chk("abort_enables_after", en_cnt, 0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_fail_count", fail_count, 8'd0);
    do_load(8'h0F, lat, m);
    chk("abort_next_latency", lat, 11);
    chk("abort_next_match", m, 1'b1);

    // Back-to-back 8'h12 then 8'h34 with in_valid held high.
    done_c1 = -1; done_c2 = -1; m1 = 1'bx; m2 = 1'bx;
    step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 35; c++) begin
      step((c <= 11), 8'h34, 1'b0, 1'b0, 1'b0);
      if (c == 11) chk("b2b_c11_in_ready", in_ready, 1'b1);
      if (done) begin
        if (done_c1 < 0) begin done_c1 = c; m1 = match; end
        else if (done_c2 < 0) begin done_c2 = c; m2 = match; end
      end
    end
    chk("b2b_done1_cycle", done_c1, 11);
    chk("b2b_done2_cycle", done_c2, 22);
    chk("b2b_match1", m1, 1'b1);
    chk("b2b_match2", m2, 1'b1);
    chk("b2b_readback", sr_stored_data, 8'h34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
